// File: rtl/sram_pkg.sv
// Shared widths and FSM state type for the SRAM arbiter.
package sram_pkg;

   localparam int unsigned SRAM_ADDR_W = 20;
   localparam int unsigned SRAM_DATA_W = 16;

   typedef enum logic [2:0] {
      StIdle,
      StRd1,
      StRd2,
      StWr1,
      StWr2
   } sram_arb_state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-cycle async SRAM arbiter: display reads have priority over render writes.
// Optional write starvation guard enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int unsigned WR_MAX_WAIT = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_rd_req,
   input  logic [SRAM_ADDR_W-1:0] i_rd_addr,
   output logic                   o_rd_gnt,
   output logic                   o_rd_valid,
   output logic [SRAM_DATA_W-1:0] o_rd_data,
   input  logic                   i_wr_req,
   input  logic [SRAM_ADDR_W-1:0] i_wr_addr,
   input  logic [SRAM_DATA_W-1:0] i_wr_data,
   output logic                   o_wr_gnt,
   output logic [SRAM_ADDR_W-1:0] o_SRAM_ADDR,
   inout  wire  [SRAM_DATA_W-1:0] io_SRAM_DQ,
   output logic                   o_SRAM_WE_N
);

   sram_arb_state_t        r_state;
   sram_arb_state_t        w_state_nxt;
   logic                   w_slot;
   logic                   w_wr_force;
   logic [SRAM_ADDR_W-1:0] r_addr;
   logic [SRAM_DATA_W-1:0] r_wdata;
   logic [SRAM_DATA_W-1:0] r_rd_data;
   logic                   r_rd_valid;

   assign w_slot = (r_state == StIdle) || (r_state == StRd2) || (r_state == StWr2);

`ifdef SRAM_ARB_STARVE_GUARD_EN
   localparam int unsigned CntW = (WR_MAX_WAIT > 0) ? $clog2(WR_MAX_WAIT + 1) : 1;
   localparam logic [CntW-1:0] MaxWait = CntW'(WR_MAX_WAIT);

   logic [CntW-1:0] r_wait_cnt;

   // Cannot overflow: once the count reaches MaxWait the held write wins the next slot.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wait_cnt <= '0;
      end else if (!i_wr_req || o_wr_gnt) begin
         r_wait_cnt <= '0;
      end else if (o_rd_gnt) begin
         r_wait_cnt <= r_wait_cnt + CntW'(1);
      end
   end

   assign w_wr_force = (r_wait_cnt >= MaxWait);
`else
   assign w_wr_force = 1'b0;
`endif

   always_comb begin
      w_state_nxt = StIdle;
      o_rd_gnt    = 1'b0;
      o_wr_gnt    = 1'b0;
      case (r_state)
         StRd1:   w_state_nxt = StRd2;
         StWr1:   w_state_nxt = StWr2;
         default: w_state_nxt = StIdle;
      endcase
      if (w_slot && !i_rst) begin
         if (i_rd_req && !(w_wr_force && i_wr_req)) begin
            o_rd_gnt    = 1'b1;
            w_state_nxt = StRd1;
         end else if (i_wr_req) begin
            o_wr_gnt    = 1'b1;
            w_state_nxt = StWr1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= StIdle;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_valid <= (r_state == StRd2);
         if (o_rd_gnt) begin
            r_addr <= i_rd_addr;
         end else if (o_wr_gnt) begin
            r_addr  <= i_wr_addr;
            r_wdata <= i_wr_data;
         end
         if (r_state == StRd2) begin
            r_rd_data <= io_SRAM_DQ;
         end
      end
   end

   // WE_N rises entering WR2 while address and data are still held.
   assign o_SRAM_WE_N = (r_state != StWr1);
   assign io_SRAM_DQ  = ((r_state == StWr1) || (r_state == StWr2)) ? r_wdata : 'z;
   assign o_SRAM_ADDR = r_addr;
   assign o_rd_valid  = r_rd_valid;
   assign o_rd_data   = r_rd_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a slot/latency reference model and an SRAM model.
module tb_sram_arbiter;

   localparam int unsigned WrMaxWait = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_req;
   logic [19:0] rd_addr;
   logic        rd_gnt;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic        wr_req;
   logic [19:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_gnt;
   logic [19:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        we_n;

   always #5 clk = ~clk;

   sram_arbiter #(
      .WR_MAX_WAIT(WrMaxWait)
   ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_rd_req   (rd_req),
      .i_rd_addr  (rd_addr),
      .o_rd_gnt   (rd_gnt),
      .o_rd_valid (rd_valid),
      .o_rd_data  (rd_data),
      .i_wr_req   (wr_req),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .o_wr_gnt   (wr_gnt),
      .o_SRAM_ADDR(sram_addr),
      .io_SRAM_DQ (sram_dq),
      .o_SRAM_WE_N(we_n)
   );

   // Async SRAM model: drives DQ during read accesses, stores on the cycle WE_N is low.
   logic [15:0] sram_mem [0:(1<<20)-1];
   logic        sram_oe = 1'b0;
   logic        sram_oe_nxt = 1'b0;

   assign sram_dq = sram_oe ? sram_mem[sram_addr] : 16'hzzzz;

   always @(posedge clk) begin
      sram_oe <= sram_oe_nxt;
      if (!we_n) sram_mem[sram_addr] <= sram_dq;
   end

   function automatic logic [15:0] init_pat(input logic [19:0] a);
      return a[15:0] ^ {a[19:16], 12'h5A3};
   endfunction

   // Reference model: accesses last two cycles, a slot opens when at most one cycle remains.
   typedef struct {
      int          due;
      logic [15:0] data;
   } rd_exp_t;

   logic [15:0] ref_mem [logic [19:0]];
   rd_exp_t     rd_q [$];
   int          m_rem = 0;
   logic        m_is_wr = 1'b0;
   logic [19:0] m_addr = '0;
   logic [15:0] m_wdata = '0;
   int unsigned m_wait = 0;
   bit          m_after_rst = 1'b0;
   bit          chk_on = 1'b0;
   int          cyc = 0;

   bit          rd_taken, wr_taken;
   int          n_rd_gnt = 0, n_wr_gnt = 0, n_valid = 0;
   int          last_rd_gnt_cyc = -1, last_wr_gnt_cyc = -1, last_valid_cyc = -1;
   int          last_wen_low_cyc = -1;
   logic [15:0] last_valid_data = '0;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   function automatic logic [15:0] ref_rd(input logic [19:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_pat(a);
   endfunction

   function automatic bit wr_forced();
`ifdef SRAM_ARB_STARVE_GUARD_EN
      return m_wait >= WrMaxWait;
`else
      return 1'b0;
`endif
   endfunction

   // Check the current cycle at negedge, advance the model, then move past the next posedge.
   task automatic step();
      bit exp_rdg, exp_wrg, exp_valid;
      @(negedge clk);
      exp_rdg = !rst && (m_rem <= 1) && rd_req && !(wr_forced() && wr_req);
      exp_wrg = !rst && (m_rem <= 1) && wr_req && !exp_rdg;
      while (rd_q.size() > 0 && rd_q[0].due < cyc) void'(rd_q.pop_front());
      exp_valid = (rd_q.size() > 0) && (rd_q[0].due == cyc);
      if (chk_on) begin
         check_eq("rd_gnt", 32'(rd_gnt), 32'(exp_rdg));
         check_eq("wr_gnt", 32'(wr_gnt), 32'(exp_wrg));
         check_eq("we_n", 32'(we_n), 32'(!(m_rem == 2 && m_is_wr)));
         check_eq("sram_addr", 32'(sram_addr), 32'(m_addr));
         if (m_rem > 0 && m_is_wr) check_eq("wr_dq", 32'(sram_dq), 32'(m_wdata));
         check_eq("rd_valid", 32'(rd_valid), 32'(exp_valid));
         if (exp_valid) check_eq("rd_data", 32'(rd_data), 32'(rd_q[0].data));
         if (m_after_rst) check_eq("rd_data_rst", 32'(rd_data), 32'h0);
      end
      if (exp_valid) void'(rd_q.pop_front());
      if (rd_gnt) begin n_rd_gnt++; last_rd_gnt_cyc = cyc; end
      if (wr_gnt) begin n_wr_gnt++; last_wr_gnt_cyc = cyc; end
      if (rd_valid) begin n_valid++; last_valid_cyc = cyc; last_valid_data = rd_data; end
      if (!we_n) last_wen_low_cyc = cyc;

      m_after_rst = rst;
      if (rst) begin
         m_rem  = 0;
         m_addr = '0;
         m_wait = 0;
         rd_q.delete();
      end else begin
         if (exp_rdg) begin
            m_rem   = 2;
            m_is_wr = 1'b0;
            m_addr  = rd_addr;
            rd_q.push_back('{due: cyc + 3, data: ref_rd(rd_addr)});
         end else if (exp_wrg) begin
            m_rem   = 2;
            m_is_wr = 1'b1;
            m_addr  = wr_addr;
            m_wdata = wr_data;
            ref_mem[wr_addr] = wr_data;
         end else if (m_rem > 0) begin
            m_rem--;
         end
         if (!wr_req || exp_wrg) m_wait = 0;
         else if (exp_rdg) m_wait++;
      end
      sram_oe_nxt = (m_rem > 0) && !m_is_wr;
      rd_taken = rd_gnt;
      wr_taken = wr_gnt;
      cyc++;
      @(posedge clk);
      #1;
      if (rd_taken) rd_req = 1'b0;
      if (wr_taken) wr_req = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int rd_before, wr_before, valid_before, t_gnt;
      for (int i = 0; i < (1 << 20); i++) sram_mem[i] = init_pat(20'(i));
      sram_mem[20'h00010] = 16'hBEEF;
      ref_mem[20'h00010]  = 16'hBEEF;
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      @(posedge clk);
      #1;
      idle(2);
      rst = 1'b0;
      chk_on = 1'b1;
      idle(2);

      // Single read of a known word.
      rd_req = 1'b1; rd_addr = 20'h00010;
      idle(5);
      check_eq("rd_latency", 32'(last_valid_cyc - last_rd_gnt_cyc), 32'd3);
      check_eq("rd_beef", 32'(last_valid_data), 32'hBEEF);

      // Single write, then read it back through the arbiter.
      wr_req = 1'b1; wr_addr = 20'h0FFFF; wr_data = 16'h1234;
      idle(4);
      check_eq("wen_low_cyc", 32'(last_wen_low_cyc - last_wr_gnt_cyc), 32'd1);
      check_eq("sram_wr", 32'(sram_mem[20'h0FFFF]), 32'h1234);
      rd_req = 1'b1; rd_addr = 20'h0FFFF;
      idle(5);
      check_eq("rd_back", 32'(last_valid_data), 32'h1234);

      // Simultaneous requests from idle: read first, write in the RD2 slot.
      rd_req = 1'b1; rd_addr = 20'h00021;
      wr_req = 1'b1; wr_addr = 20'h00022; wr_data = 16'hA55A;
      idle(6);
      check_eq("rd_then_wr", 32'(last_wr_gnt_cyc - last_rd_gnt_cyc), 32'd2);

      // Continuous reads with a held write.
      wr_req = 1'b1; wr_addr = 20'h00030; wr_data = 16'h0F0F;
      rd_before = n_rd_gnt; wr_before = n_wr_gnt;
      for (int i = 0; i < 40 && n_wr_gnt == wr_before; i++) begin
         if (!rd_req) begin rd_req = 1'b1; rd_addr = 20'($urandom_range(0, 63)); end
         step();
      end
`ifdef SRAM_ARB_STARVE_GUARD_EN
      check_eq("starve_wr_gnt", 32'(n_wr_gnt - wr_before), 32'd1);
      check_eq("starve_rd_cnt", 32'(n_rd_gnt - rd_before), 32'd8);
`else
      check_eq("strict_wr_gnt", 32'(n_wr_gnt - wr_before), 32'd0);
      check_eq("strict_rd_cnt", 32'(n_rd_gnt - rd_before), 32'd20);
`endif
      idle(8);
      check_eq("wr_drained", 32'(wr_req), 32'd0);

      // Reset during RD2 aborts the read.
      rd_req = 1'b1; rd_addr = 20'h00010;
      step();
      t_gnt = last_rd_gnt_cyc;
      step();
      valid_before = n_valid;
      rst = 1'b1; rd_req = 1'b1; rd_addr = 20'h00011; wr_req = 1'b1;
      step();
      rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
      check_eq("rst_gnt_cyc", 32'(t_gnt + 2), 32'(cyc - 1));
      idle(4);
      check_eq("rst_no_valid", 32'(n_valid - valid_before), 32'd0);

      // Randomized traffic over a small address pool, with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if (!rd_req && ($urandom_range(0, 3) != 0)) begin
            rd_req = 1'b1; rd_addr = 20'($urandom_range(0, 63));
         end
         if (!wr_req && ($urandom_range(0, 2) == 0)) begin
            wr_req = 1'b1; wr_addr = 20'($urandom_range(0, 63)); wr_data = 16'($urandom);
         end
         rst = ($urandom_range(0, 199) == 0);
         step();
         rst = 1'b0;
      end
      rd_req = 1'b0; wr_req = 1'b0;
      idle(8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
